// File: rtl/jk_mod_counter.sv
// Bank of JK cells (T flip-flop plus J/K toggle logic) that doubles as a mod-N up/down counter with load.
// q/wrap are registered (1 cycle after the sampling edge), tc is combinational; no backpressure.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH:0]   LP_N   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_cnt_wrap;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_load_val;

    // Counter next value; an out-of-range state (left over from register mode) recovers to 0 silently.
    always_comb begin
        w_cnt_nxt  = r_q;
        w_cnt_wrap = 1'b0;
        if ({1'b0, r_q} >= LP_N) begin
            w_cnt_nxt = '0;
        end else if (up_dn) begin
            if (r_q == LP_MAX) begin
                w_cnt_nxt  = '0;
                w_cnt_wrap = 1'b1;
            end else begin
                w_cnt_nxt = r_q + WIDTH'(1);
            end
        end else begin
            if (r_q == '0) begin
                w_cnt_nxt  = LP_MAX;
                w_cnt_wrap = 1'b1;
            end else begin
                w_cnt_nxt = r_q - WIDTH'(1);
            end
        end
    end

    // Both modes share the same T cells: counter mode expresses its next value as a toggle mask.
    assign w_t        = mode ? (r_q ^ w_cnt_nxt) : ((j & ~r_q) | (k & r_q));
    assign w_load_val = (mode && ({1'b0, din} >= LP_N)) ? '0 : din;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_val;
            r_wrap <= 1'b0;
        end else if (en) begin
            r_q    <= r_q ^ w_t;
            r_wrap <= mode & w_cnt_wrap;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;
    assign wrap = r_wrap;
    assign tc   = mode & ((up_dn & (r_q == LP_MAX)) | (~up_dn & (r_q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: directed scenarios plus random traffic against an arithmetic reference model.
module tb_jk_mod_counter;

    logic       clk;
    logic       rst, en, mode, up_dn, load;
    logic [3:0] j, k, din;
    logic [3:0] q, qbar, q2, qbar2;
    logic       tc, wrap, tc2, wrap2;

    int n_vec = 0;
    int n_err = 0;
    int m_q   = 0;
    int m_q2  = 0;
    bit m_w   = 0;
    bit m_w2  = 0;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .up_dn(up_dn),
        .load(load), .din(din), .q(q), .qbar(qbar), .tc(tc), .wrap(wrap)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .up_dn(up_dn),
        .load(load), .din(din), .q(q2), .qbar(qbar2), .tc(tc2), .wrap(wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: behaviour written from the functional rules, not from the cell structure.
    function automatic void model_edge(input int n, input int qin, output int qout, output bit wout);
        qout = qin;
        wout = 1'b0;
        if (rst) begin
            qout = 0;
        end else if (load) begin
            if (mode) qout = (int'(din) < n) ? int'(din) : 0;
            else      qout = int'(din);
        end else if (en) begin
            if (!mode) begin
                for (int i = 0; i < 4; i++) begin
                    case ({j[i], k[i]})
                        2'b01:   qout = qout & ~(1 << i);
                        2'b10:   qout = qout | (1 << i);
                        2'b11:   qout = qout ^ (1 << i);
                        default: ;
                    endcase
                end
            end else if (qin >= n) begin
                qout = 0;
            end else if (up_dn) begin
                qout = (qin + 1) % n;
                wout = (qin == n - 1);
            end else begin
                qout = (qin + n - 1) % n;
                wout = (qin == 0);
            end
        end
    endfunction

    function automatic bit model_tc(input int n, input int mq);
        return mode && ((up_dn && mq == n - 1) || (!up_dn && mq == 0));
    endfunction

    task automatic step();
        int nq;
        bit nw;
        @(posedge clk);
        model_edge(10, m_q, nq, nw);
        m_q = nq; m_w = nw;
        model_edge(2, m_q2, nq, nw);
        m_q2 = nq; m_w2 = nw;
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; load = 0; j = 0; k = 0; din = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; mode = 0; up_dn = 1;
        step(); step();
        n_vec++; if (q !== 4'b0000) begin n_err++; $display("FAIL reset_q got=%b exp=0000", q); end
        n_vec++; if (qbar !== 4'b1111) begin n_err++; $display("FAIL reset_qbar got=%b exp=1111", qbar); end
        n_vec++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        n_vec++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc_mode0 got=%b exp=0", tc); end
        mode = 1; up_dn = 0; #1;
        n_vec++; if (tc !== 1'b1) begin n_err++; $display("FAIL reset_tc_down got=%b exp=1", tc); end
        mode = 0; up_dn = 1;
    endtask

    task automatic test_jk();
        logic [3:0] jv [4] = '{4'b0101, 4'b0000, 4'b1111, 4'b0000};
        logic [3:0] kv [4] = '{4'b0000, 4'b0100, 4'b1111, 4'b0000};
        logic [3:0] ev [4] = '{4'b0101, 4'b0001, 4'b1110, 4'b1110};
        idle_inputs();
        mode = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            j = jv[i]; k = kv[i];
            step();
            n_vec++;
            if (q !== ev[i] || qbar !== ~ev[i]) begin
                n_err++; $display("FAIL jk_%0d got q=%b qbar=%b exp q=%b", i, q, qbar, ev[i]);
            end
        end
    endtask

    task automatic test_up_count();
        idle_inputs();
        rst = 1; step(); rst = 0;
        mode = 1; up_dn = 1; en = 1;
        for (int i = 1; i <= 12; i++) begin
            step();
            n_vec++;
            if (int'(q) !== i % 10 || wrap !== (i % 10 == 0) || tc !== (i % 10 == 9)) begin
                n_err++; $display("FAIL up_%0d got q=%0d wrap=%b tc=%b exp q=%0d", i, q, wrap, tc, i % 10);
            end
        end
        en = 0;
        step(); step();
        n_vec++;
        if (q !== 4'd2 || wrap !== 1'b0) begin
            n_err++; $display("FAIL up_hold got q=%0d wrap=%b exp q=2 wrap=0", q, wrap);
        end
    endtask

    task automatic test_down_count();
        idle_inputs();
        rst = 1; step(); rst = 0;
        mode = 1; up_dn = 0; #1;
        n_vec++; if (tc !== 1'b1) begin n_err++; $display("FAIL down_tc0 got=%b exp=1", tc); end
        en = 1;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_vec++;
            if (int'(q) !== 10 - i || wrap !== (i == 1) || tc !== 1'b0) begin
                n_err++; $display("FAIL down_%0d got q=%0d wrap=%b tc=%b exp q=%0d", i, q, wrap, tc, 10 - i);
            end
        end
    endtask

    task automatic test_load();
        idle_inputs();
        mode = 1; up_dn = 1; en = 1; load = 1; din = 4'd7;
        step();
        n_vec++; if (q !== 4'd7 || wrap !== 1'b0) begin n_err++; $display("FAIL load7 got q=%0d wrap=%b exp 7/0", q, wrap); end
        din = 4'd9; step();
        n_vec++; if (q !== 4'd9) begin n_err++; $display("FAIL load9 got=%0d exp=9", q); end
        din = 4'd12; step();
        n_vec++; if (q !== 4'd0 || wrap !== 1'b0) begin n_err++; $display("FAIL load12_m1 got q=%0d wrap=%b exp 0/0", q, wrap); end
        mode = 0; step();
        n_vec++; if (q !== 4'b1100) begin n_err++; $display("FAIL load12_m0 got=%b exp=1100", q); end
    endtask

    task automatic test_out_of_range();
        idle_inputs();
        mode = 0; en = 1; j = 4'b1111;
        step();
        n_vec++; if (q !== 4'b1111) begin n_err++; $display("FAIL oor_set got=%b exp=1111", q); end
        j = 0; mode = 1; up_dn = 1; #1;
        n_vec++; if (q !== 4'b1111 || tc !== 1'b0) begin n_err++; $display("FAIL oor_modeswitch got q=%b tc=%b exp 1111/0", q, tc); end
        step();
        n_vec++; if (q !== 4'd0 || wrap !== 1'b0) begin n_err++; $display("FAIL oor_recover got q=%0d wrap=%b exp 0/0", q, wrap); end
        step();
        n_vec++; if (q !== 4'd1 || wrap !== 1'b0) begin n_err++; $display("FAIL oor_next got q=%0d wrap=%b exp 1/0", q, wrap); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        mode = 1; up_dn = 1; load = 1; din = 4'd6;
        step();
        n_vec++; if (q !== 4'd6) begin n_err++; $display("FAIL mid_pre got=%0d exp=6", q); end
        rst = 1; din = 4'd5; en = 1;
        step();
        n_vec++; if (q !== 4'd0 || wrap !== 1'b0) begin n_err++; $display("FAIL mid_rst got q=%0d wrap=%b exp 0/0", q, wrap); end
        rst = 0; load = 0;
        step(); step(); step();
        n_vec++; if (q !== 4'd3) begin n_err++; $display("FAIL mid_resume got=%0d exp=3", q); end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        rst = 1; step(); rst = 0;
        mode = 1; en = 1;
        for (int i = 0; i < 8; i++) begin
            up_dn = (i < 4);
            step();
            n_vec++;
            if (int'(q2) !== m_q2 || wrap2 !== m_w2) begin
                n_err++; $display("FAIL b2b_%0d got q2=%0d wrap2=%b exp q2=%0d wrap2=%b", i, q2, wrap2, m_q2, m_w2);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 24) == 0);
            load  = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = ($urandom_range(0, 4) != 0);
            up_dn = $urandom_range(0, 1);
            j     = 4'($urandom);
            k     = 4'($urandom);
            din   = 4'($urandom);
            step();
            n_vec++;
            if (int'(q) !== m_q || qbar !== ~q || wrap !== m_w || tc !== model_tc(10, m_q)) begin
                n_err++; $display("FAIL rnd_n10_%0d got q=%0d wrap=%b tc=%b exp q=%0d wrap=%b tc=%b",
                                  i, q, wrap, tc, m_q, m_w, model_tc(10, m_q));
            end
            n_vec++;
            if (int'(q2) !== m_q2 || qbar2 !== ~q2 || wrap2 !== m_w2 || tc2 !== model_tc(2, m_q2)) begin
                n_err++; $display("FAIL rnd_n2_%0d got q=%0d wrap=%b tc=%b exp q=%0d wrap=%b tc=%b",
                                  i, q2, wrap2, tc2, m_q2, m_w2, model_tc(2, m_q2));
            end
        end
    endtask

    initial begin
        idle_inputs();
        mode = 0; up_dn = 1;
        test_reset();
        test_jk();
        test_up_count();
        test_down_count();
        test_load();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
